mpc_rollout_sched: RTL and testbench
====================================

Name: mpc_rollout_sched

Overview:
- Horizon sequencer for the single-step forward primal update datapath (u_k = -Kinf*x_k - d_k; x_next = A*x_k + B*u_k).
- On start, runs the datapath HORIZON times. Each step fetches d_k from the feedforward buffer, feeds the current state, kicks the datapath, waits for its done, then writes u_k and x_{k+1} to the trajectory buffer.
- Kinf, A_mat and B_mat connect directly from the configuration registers to the datapath; this block does not touch them.

Parameters:
- STATE_DIM, 12, state vector length
- CONTROL_DIM, 4, control vector length
- W, 16, signed element width
- HORIZON, 10, rollout steps (>=1)
- TIMEOUT, 255, max WAIT cycles before error (>=1)
- ADDR_W, $clog2(HORIZON), step index width (localparam, min 1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; low clears all state
- start  in  1  request rollout; accepted only in IDLE
- abort  in  1  cancel rollout
- x0  in  W x STATE_DIM signed  initial state, sampled on start accept
- busy  out  1  high in all states except IDLE/ERR
- done  out  1  one-cycle pulse, rollout complete
- err  out  1  sticky timeout flag
- step_cnt  out  ADDR_W  current step k
- d_rd_addr  out  ADDR_W  feedforward buffer read address
- d_rd_data  in  W x CONTROL_DIM signed  d_k, valid 1 cycle after address
- fp_start  out  1  datapath start pulse
- fp_x_k  out  W x STATE_DIM  registered state to datapath
- fp_d_k  out  W x CONTROL_DIM  registered d_k to datapath
- fp_done  in  1  datapath completion
- fp_u_k  in  W x CONTROL_DIM  datapath u_k
- fp_x_next  in  W x STATE_DIM  datapath x_next
- traj_wr_en  out  1  trajectory write strobe
- traj_wr_addr  out  ADDR_W  = k
- traj_u  out  W x CONTROL_DIM  u_k
- traj_x  out  W x STATE_DIM  x_{k+1}

Behaviour:
- Reset (async, low): state=IDLE. All outputs, k, the watchdog and all data registers go to 0.
- States: IDLE, FETCH, LOAD, KICK, WAIT, STORE, FINISH, ERR.
- IDLE: start=1 and abort=0 -> x_reg<=x0, k<=0, err<=0, next FETCH.
- FETCH: d_rd_addr=k (held through LOAD) -> LOAD.
- LOAD: fp_d_k<=d_rd_data; fp_x_k<=x_reg -> KICK.
- KICK: fp_start=1 for exactly this cycle; watchdog<=0 -> WAIT.
- fp_done is ignored during KICK. The datapath must drop a stale done within 1 cycle of fp_start.
- WAIT: the first cycle with fp_done=1 captures fp_u_k/fp_x_next -> STORE.
- WAIT timeout: otherwise watchdog++; if watchdog==TIMEOUT-1 with no fp_done -> ERR.
- STORE: traj_wr_en=1 for one cycle, addr=k; x_reg<=captured x_next.
  - k==HORIZON-1 -> FINISH.
  - Otherwise k++ -> FETCH.
- FINISH: done=1 for one cycle -> IDLE.
- ERR: err=1 (sticky), busy=0. Leave only via an accepted start, which clears err and starts a new rollout.
- Step latency: 5 + L cycles, where L = cycles from fp_start to first fp_done (L>=1).
- Total latency: start accept to done = HORIZON*(5+L)+1 cycles.
- abort=1 in any busy state: next state IDLE.
  - No further fp_start or traj_wr_en; no done pulse.
  - If abort coincides with STORE, that write still occurs.
- abort and start together in IDLE: abort wins; stay IDLE.
- start while busy: ignored; no restart.
- Data is passed through unmodified, with no arithmetic or saturation. x_reg is W-bit signed per element.
- Reset mid-rollout: immediate return to IDLE; any in-progress write strobe drops asynchronously.

Decomposition:
- Shared package mpc_pkg:
  - sched_state_t enum (state list above)
  - default STATE_DIM/CONTROL_DIM/W constants
  - typedefs state_vec_t (W x STATE_DIM signed) and ctrl_vec_t (W x CONTROL_DIM signed), shared with the datapath
- One sub-module: mpc_watchdog. Loadable counter with clear/enable and an expired output, parameterised by TIMEOUT, reusable for the backward pass sequencer.

Test Plan:
- Nominal, HORIZON=3, real datapath:
  - Stimulus: A=I, B=[I4;0], Kinf=0, x0=1..12, d_k=[1,2,3,4] every step.
  - Required traj_u at every addr: [-1,-2,-3,-4].
  - Required traj_x[0..3]: addr0 [0,0,0,0]; addr1 [-1,-2,-3,-4]; addr2 [-2,-4,-6,-8].
  - Required traj_x[4..11] = 5..12 at every addr; exactly 3 traj_wr_en pulses, then 1 done pulse.
- Latency, model datapath with L=4, HORIZON=3: done exactly 28 cycles after start accept; fp_start exactly 3 pulses, each 1 cycle.
- Timeout, model never raises fp_done, TIMEOUT=8: ERR entered 8 cycles after fp_start; err=1, busy=0, no write, no done; next start clears err and completes normally.
- Abort in WAIT of step 1 (HORIZON=3): IDLE next cycle; only the addr0 write occurred; no done; a subsequent start runs all 3 steps from k=0.
- Start while busy, plus start+abort together in IDLE: extra start ignored (step_cnt is not reset); simultaneous start+abort leaves busy=0.
- Async reset low asserted mid-STORE: traj_wr_en, busy, done and fp_start all go to 0 without waiting for a clock edge; after release, state is IDLE and step_cnt=0.

Source files
------------

// File: rtl/mpc_rollout_sched_pkg.sv
// Shared types for the MPC rollout datapath and its sequencers.
//   sched_state_t : rollout sequencer states
//   state_vec_t   : W x STATE_DIM signed state vector
//   ctrl_vec_t    : W x CONTROL_DIM signed control vector
//   addr_w()      : index width for a given step count (minimum 1)
package mpc_pkg;

    localparam int unsigned STATE_DIM   = 12;
    localparam int unsigned CONTROL_DIM = 4;
    localparam int unsigned W           = 16;

    typedef logic signed [STATE_DIM-1:0][W-1:0]   state_vec_t;
    typedef logic signed [CONTROL_DIM-1:0][W-1:0] ctrl_vec_t;

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, KICK, WAIT, STORE, FINISH, ERR
    } sched_state_t;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpc_rollout_sched_if.sv
// Rollout sequencer memory/datapath bus.
//   d_rd_*   : feedforward buffer read port (data one cycle after address)
//   fp_*     : forward-pass datapath handshake and operands/results
//   traj_*   : trajectory buffer write port
// master = sequencer side, slave = buffers/datapath side.
interface mpc_rollout_sched_if #(
    parameter int unsigned ADDR_W = 4
) ();
    import mpc_pkg::*;

    logic [ADDR_W-1:0] d_rd_addr;
    ctrl_vec_t         d_rd_data;
    logic              fp_start;
    state_vec_t        fp_x_k;
    ctrl_vec_t         fp_d_k;
    logic              fp_done;
    ctrl_vec_t         fp_u_k;
    state_vec_t        fp_x_next;
    logic              traj_wr_en;
    logic [ADDR_W-1:0] traj_wr_addr;
    ctrl_vec_t         traj_u;
    state_vec_t        traj_x;

    modport master (
        output d_rd_addr, fp_start, fp_x_k, fp_d_k, traj_wr_en, traj_wr_addr, traj_u, traj_x,
        input  d_rd_data, fp_done, fp_u_k, fp_x_next
    );

    modport slave (
        input  d_rd_addr, fp_start, fp_x_k, fp_d_k, traj_wr_en, traj_wr_addr, traj_u, traj_x,
        output d_rd_data, fp_done, fp_u_k, fp_x_next
    );

endinterface

// File: rtl/mpc_watchdog.sv
// Loadable cycle watchdog.
//   clear     : synchronous clear to 0 (highest priority)
//   load      : load load_val
//   enable    : count up; holds once expired
//   expired_c : count has reached TIMEOUT-1
module mpc_watchdog #(
    parameter int unsigned  TIMEOUT = 255,
    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt;

    assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

    // Counter holds at expiry so it never wraps back to a live value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && !expired_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mpc_rollout_sched.sv
// Horizon sequencer for the forward primal update datapath.
// Runs the datapath HORIZON times from x0, feeding back x_next as the
// next state and writing (u_k, x_{k+1}) to the trajectory buffer at k.
//   clk, reset      : clock, async active-low reset
//   start, abort, x0: rollout request / cancel / initial state
//   busy, done, err : activity, completion pulse, sticky timeout flag
//   step_cnt        : current step index k
//   bus             : feedforward read, datapath handshake, trajectory write
module mpc_rollout_sched
    import mpc_pkg::*;
#(
    parameter int unsigned  HORIZON = 10,
    parameter int unsigned  TIMEOUT = 255,
    localparam int unsigned ADDR_W  = addr_w(HORIZON)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  state_vec_t           x0,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W-1:0]    step_cnt,
    mpc_rollout_sched_if.master  bus
);

    sched_state_t      state;
    logic [ADDR_W-1:0] k;
    state_vec_t        x_reg;
    state_vec_t        x_k_q;
    ctrl_vec_t         d_k_q;
    ctrl_vec_t         traj_u_q;
    state_vec_t        traj_x_q;
    logic              fp_start_q;
    logic              wr_en_q;
    logic              wd_clear;
    logic              wd_enable;
    logic              wd_expired;

    // Watchdog restarts in KICK and counts WAIT cycles without fp_done.
    assign wd_clear  = (state == KICK);
    assign wd_enable = (state == WAIT) && !bus.fp_done;

    mpc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (wd_clear),
        .load      (1'b0),
        .load_val  ('0),
        .enable    (wd_enable),
        .expired_c (wd_expired)
    );

    assign step_cnt         = k;
    assign bus.d_rd_addr    = k;
    assign bus.traj_wr_addr = k;
    assign bus.fp_start     = fp_start_q;
    assign bus.fp_x_k       = x_k_q;
    assign bus.fp_d_k       = d_k_q;
    assign bus.traj_wr_en   = wr_en_q;
    assign bus.traj_u       = traj_u_q;
    assign bus.traj_x       = traj_x_q;

    // Sequencer; pulse outputs default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            k          <= '0;
            x_reg      <= '0;
            x_k_q      <= '0;
            d_k_q      <= '0;
            traj_u_q   <= '0;
            traj_x_q   <= '0;
            fp_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            fp_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            done       <= 1'b0;
            // busy mirrors "not IDLE/ERR", so it doubles as the abort qualifier.
            if (abort && busy) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, ERR: begin
                        if (start && !abort) begin
                            x_reg <= x0;
                            k     <= '0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= FETCH;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        d_k_q      <= bus.d_rd_data;
                        x_k_q      <= x_reg;
                        fp_start_q <= 1'b1;
                        state      <= KICK;
                    end
                    KICK: state <= WAIT;
                    WAIT: begin
                        if (bus.fp_done) begin
                            traj_u_q <= bus.fp_u_k;
                            traj_x_q <= bus.fp_x_next;
                            wr_en_q  <= 1'b1;
                            state    <= STORE;
                        end else if (wd_expired) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= ERR;
                        end
                    end
                    STORE: begin
                        x_reg <= traj_x_q;
                        if (k == ADDR_W'(HORIZON - 1)) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            k     <= k + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpc_rollout_sched.sv
// Bench for mpc_rollout_sched: feedforward buffer, matrix-form forward-pass
// datapath with programmable latency, and an independent rollout reference.
module tb_mpc_rollout_sched;
    import mpc_pkg::*;

    localparam int unsigned HOR = 3;
    localparam int unsigned TMO = 8;
    localparam int unsigned AW  = addr_w(HOR);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    state_vec_t    x0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] step_cnt;

    mpc_rollout_sched_if #(.ADDR_W(AW)) bus ();

    mpc_rollout_sched #(.HORIZON(HOR), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .x0       (x0),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .step_cnt (step_cnt),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Plant and stimulus data
    int      A [12][12];
    int      B [12][4];
    int      K [4][12];
    shortint x0_arr [12];
    shortint d_mem [4][4];
    int      dp_lat  = 1;
    bit      dp_hang = 1'b0;

    // Observations collected at every rising edge
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         kick_cnt = 0;
    int         kick_wide = 0;
    int         kick_cyc = 0;
    bit         prev_kick = 1'b0;
    int         lat_left = 0;
    bit         pending = 1'b0;
    int         wr_addr_q [$];
    ctrl_vec_t  wr_u_q [$];
    state_vec_t wr_x_q [$];
    ctrl_vec_t  rd_tmp;
    ctrl_vec_t  dp_u_v;
    state_vec_t dp_x_v;
    shortint    dp_x [12];
    shortint    dp_d [4];
    shortint    dp_u [4];
    int         acc;

    // Reference trajectory
    ctrl_vec_t  exp_u [HOR];
    state_vec_t exp_x [HOR];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.traj_wr_en) begin
            wr_addr_q.push_back(int'(bus.traj_wr_addr));
            wr_u_q.push_back(bus.traj_u);
            wr_x_q.push_back(bus.traj_x);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        for (int j = 0; j < 4; j++) rd_tmp[j] = d_mem[bus.d_rd_addr][j];
        bus.d_rd_data <= rd_tmp;
        bus.fp_done   <= 1'b0;
        if (bus.fp_start) begin
            if (prev_kick) kick_wide = kick_wide + 1;
            kick_cnt = kick_cnt + 1;
            kick_cyc = cyc;
            for (int i = 0; i < 12; i++) dp_x[i] = shortint'($signed(bus.fp_x_k[i]));
            for (int j = 0; j < 4; j++)  dp_d[j] = shortint'($signed(bus.fp_d_k[j]));
            lat_left = dp_lat;
            pending  = 1'b1;
        end else if (pending) begin
            lat_left = lat_left - 1;
            if (lat_left <= 0) begin
                pending = 1'b0;
                if (!dp_hang) begin
                    // u = -Kinf*x - d ; x_next = A*x + B*u
                    for (int j = 0; j < 4; j++) begin
                        acc = 0;
                        for (int i = 0; i < 12; i++) acc += K[j][i] * int'(dp_x[i]);
                        dp_u[j]   = shortint'(-acc - int'(dp_d[j]));
                        dp_u_v[j] = dp_u[j];
                    end
                    for (int i = 0; i < 12; i++) begin
                        acc = 0;
                        for (int m = 0; m < 12; m++) acc += A[i][m] * int'(dp_x[m]);
                        for (int j = 0; j < 4; j++)  acc += B[i][j] * int'(dp_u[j]);
                        dp_x_v[i] = 16'(acc);
                    end
                    bus.fp_done   <= 1'b1;
                    bus.fp_u_k    <= dp_u_v;
                    bus.fp_x_next <= dp_x_v;
                end
            end
        end
        prev_kick = bus.fp_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Rollout by rule: Kinf=0 so u_k=-d_k; x_{k+1} = x_k with u_k added to elements 0..3.
    task automatic build_expected();
        shortint xs [12];
        shortint u;
        for (int i = 0; i < 12; i++) begin
            xs[i]  = x0_arr[i];
            x0[i]  = x0_arr[i];
        end
        for (int k = 0; k < int'(HOR); k++) begin
            for (int j = 0; j < 4; j++) begin
                u           = -d_mem[k][j];
                exp_u[k][j] = u;
                xs[j]       = xs[j] + u;
            end
            for (int i = 0; i < 12; i++) exp_x[k][i] = xs[i];
        end
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < 12; i++) x0_arr[i] = shortint'(int'($urandom_range(400)) - 200);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) d_mem[k][j] = shortint'(int'($urandom_range(200)) - 100);
    endtask

    task automatic check_traj(input int base, input int n);
        chk("wr_count", 192'(wr_addr_q.size() - base), 192'(n));
        for (int k = 0; k < n && base + k < wr_addr_q.size(); k++) begin
            chk($sformatf("wr_addr[%0d]", k), 192'(wr_addr_q[base + k]), 192'(k));
            chk($sformatf("traj_u[%0d]", k),  192'(wr_u_q[base + k]),    192'(exp_u[k]));
            chk($sformatf("traj_x[%0d]", k),  192'(wr_x_q[base + k]),    192'(exp_x[k]));
        end
    endtask

    // Full rollout from IDLE; returns start-accept to done latency.
    task automatic do_rollout(input int L, output int lat);
        int c0, wb, db, kb, kw;
        dp_lat = L;
        build_expected();
        wb = wr_addr_q.size();
        db = done_cnt;
        kb = kick_cnt;
        kw = kick_wide;
        c0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 500 && done_cnt == db; i++) tick();
        lat = done_cyc - (c0 + 1);
        repeat (4) tick();
        chk("done_pulses", 192'(done_cnt - db), 192'(1));
        chk("kick_pulses", 192'(kick_cnt - kb), 192'(HOR));
        chk("kick_width",  192'(kick_wide - kw), 192'(0));
        chk("busy_after",  192'(busy), 192'(0));
        check_traj(wb, int'(HOR));
    endtask

    initial begin
        int lat, L, wb, db, kb, c0;

        for (int i = 0; i < 12; i++) begin
            for (int m = 0; m < 12; m++) A[i][m] = (i == m) ? 1 : 0;
            for (int j = 0; j < 4; j++)  B[i][j] = (i == j) ? 1 : 0;
        end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 12; i++) K[j][i] = 0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) d_mem[k][j] = 16'sd0;

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        x0    = '0;
        repeat (2) tick();
        chk("rst_busy",     192'(busy), 192'(0));
        chk("rst_done",     192'(done), 192'(0));
        chk("rst_err",      192'(err), 192'(0));
        chk("rst_step",     192'(step_cnt), 192'(0));
        chk("rst_fp_start", 192'(bus.fp_start), 192'(0));
        chk("rst_wr_en",    192'(bus.traj_wr_en), 192'(0));
        reset = 1'b1;
        tick();

        // Nominal: x0 = 1..12, d_k = [1,2,3,4]
        for (int i = 0; i < 12; i++) x0_arr[i] = shortint'(i + 1);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) d_mem[k][j] = shortint'(j + 1);
        do_rollout(2, lat);

        // Latency with L=4: 3*(5+4)+1
        randomize_stim();
        do_rollout(4, lat);
        chk("latency_L4", 192'(lat), 192'(28));

        // Random data and latency
        for (int r = 0; r < 3; r++) begin
            randomize_stim();
            L = int'($urandom_range(1, 6));
            do_rollout(L, lat);
            chk($sformatf("latency_L%0d", L), 192'(lat), 192'(int'(HOR) * (5 + L) + 1));
        end

        // Timeout: datapath never completes
        randomize_stim();
        build_expected();
        dp_hang = 1'b1;
        wb = wr_addr_q.size();
        db = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && err !== 1'b1; i++) tick();
        chk("tmo_err",      192'(err), 192'(1));
        chk("tmo_delay",    192'(cyc - kick_cyc), 192'(TMO));
        chk("tmo_busy",     192'(busy), 192'(0));
        repeat (3) tick();
        chk("tmo_err_hold", 192'(err), 192'(1));
        chk("tmo_no_write", 192'(wr_addr_q.size() - wb), 192'(0));
        chk("tmo_no_done",  192'(done_cnt - db), 192'(0));
        dp_hang = 1'b0;
        db = done_cnt;
        wb = wr_addr_q.size();
        dp_lat = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo_err_clr",  192'(err), 192'(0));
        for (int i = 0; i < 200 && done_cnt == db; i++) tick();
        tick();
        chk("tmo_recover_done", 192'(done_cnt - db), 192'(1));
        check_traj(wb, int'(HOR));

        // Abort in WAIT of step 1
        randomize_stim();
        build_expected();
        dp_lat = 4;
        wb = wr_addr_q.size();
        db = done_cnt;
        kb = kick_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !(bus.fp_start === 1'b1 && step_cnt == AW'(1)); i++) tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 192'(busy), 192'(0));
        repeat (20) tick();
        chk("abort_writes", 192'(wr_addr_q.size() - wb), 192'(1));
        if (wr_addr_q.size() > wb) chk("abort_wr_addr", 192'(wr_addr_q[wb]), 192'(0));
        chk("abort_no_done", 192'(done_cnt - db), 192'(0));
        chk("abort_kicks",   192'(kick_cnt - kb), 192'(2));
        do_rollout(2, lat);

        // Start while busy is ignored
        randomize_stim();
        build_expected();
        dp_lat = 3;
        wb = wr_addr_q.size();
        db = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && step_cnt != AW'(1); i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_step", 192'(step_cnt), 192'(1));
        chk("busy_start_busy", 192'(busy), 192'(1));
        for (int i = 0; i < 200 && done_cnt == db; i++) tick();
        tick();
        chk("busy_start_done", 192'(done_cnt - db), 192'(1));
        check_traj(wb, int'(HOR));

        // start+abort together in IDLE
        kb = kick_cnt;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 192'(busy), 192'(0));
        repeat (6) tick();
        chk("start_abort_kicks", 192'(kick_cnt - kb), 192'(0));

        // Async reset while in STORE
        randomize_stim();
        build_expected();
        dp_lat = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = 0;
        for (int i = 0; i < 100 && bus.traj_wr_en !== 1'b1; i++) tick();
        chk("store_reached", 192'(bus.traj_wr_en), 192'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_wr_en",    192'(bus.traj_wr_en), 192'(0));
        chk("arst_busy",     192'(busy), 192'(0));
        chk("arst_done",     192'(done), 192'(0));
        chk("arst_fp_start", 192'(bus.fp_start), 192'(0));
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("arst_step", 192'(step_cnt), 192'(0));
        chk("arst_idle", 192'(busy), 192'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
